input_conditioner: RTL and testbench

//  Conditions raw board inputs (push button, slide switch) for the stopwatch datapath.

---
 rtl/input_conditioner_pkg.sv | 13 +
 rtl/input_conditioner_debounce_cell.sv | 49 ++++
 rtl/input_conditioner.sv | 88 ++++++++
 tb/tb_input_conditioner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared types and default timing constants for input_conditioner
package input_conditioner_pkg;

  localparam int DEBOUNCE_CYCLES_DEF   = 16;
  localparam int LONG_PRESS_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } btn_state_t;

endpackage

// File: rtl/input_conditioner_debounce_cell.sv
// rtl/input_conditioner_debounce_cell.sv - 2-flop synchroniser, debounce counter and edge pulses for one input
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      // Any sample agreeing with the stable level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced button/switch levels with press, release, long-press and toggle pulses
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  input  logic switch,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic sw_level,
  output logic sw_toggle
);

  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] LONG_AT   = HW'(LONG_PRESS_CYCLES - 2);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_PRESS_CYCLES - 1);

  btn_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          b_rise;
  logic          b_fall;
  logic          s_rise;
  logic          s_fall;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock (clock),
    .reset (reset),
    .din   (button),
    .level (btn_level),
    .rise  (b_rise),
    .fall  (b_fall)
  );

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
    .clock (clock),
    .reset (reset),
    .din   (switch),
    .level (sw_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  // The FSM enters PRESSED one cycle after btn_press, so hold_cnt lags the press by one.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (b_rise) begin
            state    <= PRESSED;
            hold_cnt <= '0;
          end
        end
        PRESSED: begin
          if (b_fall) begin
            state <= IDLE;
          end else if (hold_cnt == LONG_AT) begin
            state    <= LONG_HELD;
            hold_cnt <= LONG_LAST;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (b_fall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign btn_press   = b_rise;
  assign btn_release = b_fall;
  // Decoded from flops so a release landing on the threshold cycle suppresses the long pulse.
  assign btn_long    = (state == PRESSED) && (hold_cnt == LONG_AT) && !b_fall;
  assign sw_toggle   = s_rise | s_fall;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner with a windowed debounce model
module tb_input_conditioner;
  import input_conditioner_pkg::*;

  localparam int DB = 16;
  localparam int LP = 256;

  logic clock = 1'b0;
  logic reset;
  logic button;
  logic switch;
  logic btn_level, btn_press, btn_release, btn_long, sw_level, sw_toggle;

  input_conditioner #(.DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)) dut (
    .clock       (clock),
    .reset       (reset),
    .button      (button),
    .switch      (switch),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .sw_level    (sw_level),
    .sw_toggle   (sw_toggle)
  );

  always #1 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int cnt_press = 0, cnt_release = 0, cnt_long = 0, cnt_toggle = 0;
  bit started = 0;

  // Model: a channel's level flips once its last DB pin samples (seen 2 edges late) all disagree with it.
  logic pipe [2][2];
  logic win  [2][DB];
  logic lvl  [2];
  int   since;
  bit   long_done;
  int   m_press_cyc = -1;
  logic exp_blevel, exp_press, exp_release, exp_long, exp_slevel, exp_toggle;

  task automatic step_ch(input int ch, input logic pin, output logic changed);
    logic s;
    bit   all_diff;
    s = pipe[ch][1];
    pipe[ch][1] = pipe[ch][0];
    pipe[ch][0] = pin;
    for (int i = DB - 1; i > 0; i--) win[ch][i] = win[ch][i-1];
    win[ch][0] = s;
    all_diff = 1;
    for (int i = 0; i < DB; i++) if (win[ch][i] == lvl[ch]) all_diff = 0;
    changed = all_diff;
    if (all_diff) begin
      lvl[ch] = ~lvl[ch];
      for (int i = 0; i < DB; i++) win[ch][i] = lvl[ch];
    end
  endtask

  always @(posedge clock) begin
    logic bchg, schg;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        pipe[c][0] = 1'b0;
        pipe[c][1] = 1'b0;
        lvl[c] = 1'b0;
        for (int i = 0; i < DB; i++) win[c][i] = 1'b0;
      end
      since = 0;
      long_done = 1;
      {exp_blevel, exp_press, exp_release, exp_long, exp_slevel, exp_toggle} = '0;
    end else begin
      step_ch(0, button, bchg);
      step_ch(1, switch, schg);
      exp_blevel  = lvl[0];
      exp_press   = bchg && lvl[0];
      exp_release = bchg && !lvl[0];
      if (exp_press) begin
        since = 0;
        long_done = 0;
        m_press_cyc = cyc + 1;
      end else if (lvl[0]) begin
        since++;
      end
      exp_long = lvl[0] && !exp_press && !long_done && (since == LP - 1);
      if (exp_long) long_done = 1;
      exp_slevel = lvl[1];
      exp_toggle = schg;
    end
  end

  always @(negedge clock) begin
    logic [5:0] act, want;
    if (started) begin
      act  = {btn_level, btn_press, btn_release, btn_long, sw_level, sw_toggle};
      want = {exp_blevel, exp_press, exp_release, exp_long, exp_slevel, exp_toggle};
      tests++;
      if (act !== want) begin
        fails++;
        $display("FAIL model_compare cyc=%0d got=%b want=%b (lvl,press,rel,long,swlvl,tog)", cyc, act, want);
      end
      tests++;
      if (!$onehot0({btn_press, btn_release, btn_long})) begin
        fails++;
        $display("FAIL pulse_exclusive cyc=%0d got=%b want=at most one", cyc, {btn_press, btn_release, btn_long});
      end
      cnt_press   += int'(btn_press);
      cnt_release += int'(btn_release);
      cnt_long    += int'(btn_long);
      cnt_toggle  += int'(sw_toggle);
    end
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // sel: 0 press, 1 release, 2 long, 3 toggle; at = -1 when the bound expires.
  task automatic wait_sig(input int sel, input int bound, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      case (sel)
        0:       v = btn_press;
        1:       v = btn_release;
        2:       v = btn_long;
        default: v = sw_toggle;
      endcase
      if (v === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, at, p_at, l0, p0, r0, tg0;
    reset = 1'b1;
    button = 1'b0;
    switch = 1'b0;

    // Reset and idle
    tick(1);
    started = 1;
    tick(1);
    check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_long, sw_level, sw_toggle}), 0);
    reset = 1'b0;
    tick(50);
    check("idle_no_pulses", cnt_press + cnt_release + cnt_long + cnt_toggle, 0);
    check("idle_level", int'(btn_level), 0);

    // Clean press and release
    c0 = cyc;
    button = 1'b1;
    wait_sig(0, 100, at);
    check("press_latency", at - c0, 18);
    check("model_press_latency", m_press_cyc - c0, 18);
    check("press_level", int'(btn_level), 1);
    c0 = cyc;
    button = 1'b0;
    wait_sig(1, 100, at);
    check("release_latency", at - c0, 18);
    tick(20);

    // Bounce: 12 segments of 5 cycles, then held high
    p0 = cnt_press;
    r0 = cnt_release;
    for (int k = 0; k < 12; k++) begin
      button = (k % 2 == 0);
      tick(5);
    end
    button = 1'b1;
    c0 = cyc;
    wait_sig(0, 100, at);
    p_at = at;
    check("bounce_press_latency", at - c0, 18);
    tick(1);
    check("bounce_press_count", cnt_press - p0, 1);
    check("bounce_no_release", cnt_release - r0, 0);

    // Long hold of 600 cycles
    l0 = cnt_long;
    p0 = cnt_press;
    wait_sig(2, 400, at);
    check("long_latency", at - p_at, 255);
    tick(p_at + 600 - cyc);
    check("long_once", cnt_long - l0, 1);
    check("hold_no_press", cnt_press - p0, 0);
    r0 = cnt_release;
    c0 = cyc;
    button = 1'b0;
    wait_sig(1, 100, at);
    check("long_release_latency", at - c0, 18);
    tick(1);
    check("long_release_once", cnt_release - r0, 1);
    check("state_idle", int'(dut.state), int'(IDLE));
    check("long_none_after", cnt_long - l0, 1);
    tick(30);

    // Release landing exactly on the long threshold: release wins
    button = 1'b1;
    wait_sig(0, 100, p_at);
    tick(237);
    l0 = cnt_long;
    button = 1'b0;
    wait_sig(1, 100, at);
    check("collide_release_at", at - p_at, 255);
    tick(1);
    check("collide_no_long", cnt_long - l0, 0);
    tick(30);

    // Switch toggles 500 cycles apart, then short glitches
    c0 = cyc;
    switch = 1'b1;
    wait_sig(3, 100, at);
    check("sw_rise_latency", at - c0, 18);
    check("sw_level_high", int'(sw_level), 1);
    tick(c0 + 500 - cyc);
    c0 = cyc;
    switch = 1'b0;
    wait_sig(3, 100, at);
    check("sw_fall_latency", at - c0, 18);
    check("sw_level_low", int'(sw_level), 0);
    tick(5);
    tg0 = cnt_toggle;
    switch = 1'b1;
    tick(8);
    switch = 1'b0;
    tick(60);
    check("glitch8_no_toggle", cnt_toggle - tg0, 0);
    switch = 1'b1;
    tick(15);
    switch = 1'b0;
    tick(60);
    check("glitch15_no_toggle", cnt_toggle - tg0, 0);
    check("glitch_sw_level", int'(sw_level), 0);

    // Simultaneous button and switch events
    button = 1'b1;
    switch = 1'b1;
    wait_sig(0, 100, at);
    check("simul_toggle_with_press", int'(sw_toggle), 1);

    // Reset in the middle of a hold
    tick(20);
    reset = 1'b1;
    tick(1);
    check("reset_mid_outputs", int'({btn_level, btn_press, btn_release, btn_long, sw_level, sw_toggle}), 0);
    tick(1);
    reset = 1'b0;
    c0 = cyc;
    wait_sig(0, 100, at);
    check("press_after_reset", at - c0, 18);

    button = 1'b0;
    switch = 1'b0;
    tick(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
